// File: rtl/gearbox_fifo_pkg.sv
// gearbox_fifo_pkg: shared types and helpers for the width-converting FIFO.
// Holds the drain FSM state type, the modulo pointer-advance helper and
// width helpers used to size pointers and the fill-level counter.
package gearbox_fifo_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } gb_state_e;

    // Advance a ring index by inc, wrapping once at depth. Callers never
    // advance by more than depth, so a single compare-and-subtract is enough
    // and depth does not have to be a power of two.
    function automatic int ptr_add(input int ptr, input int inc, input int depth);
        int sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

    // Bits needed to hold a ring index 0..depth-1.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Bits needed to hold a fill level 0..depth.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gearbox_ring.sv
// gearbox_ring: DEPTH-entry word store with an IN_SIZE-word write port at
// wr_ptr and an OUT_SIZE-word combinational read port at rd_ptr. Both ports
// wrap individually per word, so beats that straddle the end of the ring
// split correctly for any depth.
module gearbox_ring
    import gearbox_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int DEPTH     = 28,
    parameter int IN_SIZE   = 14,
    parameter int OUT_SIZE  = 1,
    parameter int PTRW      = ptr_width(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [PTRW-1:0]               wr_ptr,
    input  logic [IN_SIZE*DATAWIDTH-1:0]  wr_data,
    input  logic [PTRW-1:0]               rd_ptr,
    output logic [OUT_SIZE*DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    // Store a whole input beat, word k landing k slots after wr_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < IN_SIZE; k++) begin
                mem[PTRW'(ptr_add(int'(wr_ptr), k, DEPTH))] <= wr_data[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Present the OUT_SIZE oldest words starting at rd_ptr.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < OUT_SIZE; k++) begin
            rd_data[k*DATAWIDTH +: DATAWIDTH] = mem[PTRW'(ptr_add(int'(rd_ptr), k, DEPTH))];
        end
    end

endmodule

// File: rtl/gearbox_fifo.sv
// gearbox_fifo: width-converting FIFO taking IN_SIZE words per input beat
// and delivering OUT_SIZE words per output beat, with ready/valid on both
// sides and a word-level fill report.
// Define GEARBOX_FIFO_FLUSH_EN to add the flush input and dout_keep output:
// a flush pulse drains any residual shorter than a full output beat.
module gearbox_fifo
    import gearbox_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int DEPTH     = 28,
    parameter int IN_SIZE   = 14,
    parameter int OUT_SIZE  = 1,
    parameter int LVLW      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IN_SIZE*DATAWIDTH-1:0]  din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [OUT_SIZE*DATAWIDTH-1:0] dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [LVLW-1:0]               level
`ifdef GEARBOX_FIFO_FLUSH_EN
    ,
    input  logic                          flush,
    output logic [OUT_SIZE-1:0]           dout_keep
`endif
);

    localparam int              PTRW      = ptr_width(DEPTH);
    localparam logic [LVLW-1:0] IN_WORDS  = LVLW'(IN_SIZE);
    localparam logic [LVLW-1:0] OUT_WORDS = LVLW'(OUT_SIZE);
    localparam logic [LVLW-1:0] MAX_FILL  = LVLW'(DEPTH - IN_SIZE);

    logic [PTRW-1:0]               wr_ptr;
    logic [PTRW-1:0]               rd_ptr;
    logic [LVLW-1:0]               count;
    logic [LVLW-1:0]               count_next;
    logic [LVLW-1:0]               rd_words;
    logic                          wr_fire;
    logic                          rd_fire;
    logic                          has_space;
    logic [OUT_SIZE*DATAWIDTH-1:0] ring_data;

    // Ready depends only on the registered count, so room freed by a read
    // shows up one cycle later and no combinational path exists from
    // dout_ready to din_ready.
    assign has_space = (count <= MAX_FILL);
    assign wr_fire   = din_valid & din_ready;
    assign rd_fire   = dout_valid & dout_ready;
    assign level     = count;

    gearbox_ring #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .IN_SIZE   (IN_SIZE),
        .OUT_SIZE  (OUT_SIZE),
        .PTRW      (PTRW)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_fire),
        .wr_ptr  (wr_ptr),
        .wr_data (din),
        .rd_ptr  (rd_ptr),
        .rd_data (ring_data)
    );

    // Fill level after this cycle's accepted write and read.
    always_comb begin
        count_next = count + (wr_fire ? IN_WORDS : '0) - (rd_fire ? rd_words : '0);
    end

    // Ring pointers and fill count; a read frees rd_words slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= PTRW'(ptr_add(int'(wr_ptr), IN_SIZE, DEPTH));
            end
            if (rd_fire) begin
                rd_ptr <= PTRW'(ptr_add(int'(rd_ptr), int'(rd_words), DEPTH));
            end
            count <= count_next;
        end
    end

`ifdef GEARBOX_FIFO_FLUSH_EN
    gb_state_e state;
    gb_state_e state_next;

    // Drain-mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // Enter DRAIN on a flush with data held; leave once the FIFO empties.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL: if (flush && (count != '0)) state_next = DRAIN;
            DRAIN:  if (count_next == '0)       state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    // In DRAIN the input is held off and short beats go out zero-padded,
    // with keep marking how many leading words are real.
    always_comb begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        rd_words   = OUT_WORDS;
        dout       = '0;
        dout_keep  = '0;
        if (state == NORMAL) begin
            din_ready  = has_space;
            dout_valid = (count >= OUT_WORDS);
        end else begin
            dout_valid = (count != '0);
            rd_words   = (count < OUT_WORDS) ? count : OUT_WORDS;
        end
        for (int k = 0; k < OUT_SIZE; k++) begin
            dout_keep[k] = (LVLW'(k) < rd_words);
            if (dout_keep[k]) begin
                dout[k*DATAWIDTH +: DATAWIDTH] = ring_data[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end
`else
    // Without flush, only full output beats are ever offered.
    always_comb begin
        din_ready  = has_space;
        dout_valid = (count >= OUT_WORDS);
        rd_words   = OUT_WORDS;
        dout       = ring_data;
    end
`endif

endmodule

// File: doc/gearbox_fifo.md
Name: gearbox_fifo

Overview:
- Parametrised width-converting FIFO.
- Accepts IN_SIZE words per beat and delivers OUT_SIZE words per beat, with full ready/valid backpressure on both sides.
- Replaces the fixed wide-in/narrow-out request-driven FIFO used ahead of the H and x conversion paths.
- Any IN_SIZE:OUT_SIZE ratio is supported (J:1, 1:J, 4:3, ...), plus fill-level reporting and an optional partial-beat flush.

Parameters:
- DATAWIDTH, 64, bits per word
- DEPTH, 28, storage capacity in words; must satisfy DEPTH >= IN_SIZE + OUT_SIZE; need not be a power of two
- IN_SIZE, 14, words accepted per input beat
- OUT_SIZE, 1, words delivered per output beat
- LVLW, $clog2(DEPTH+1), width of level output (derived)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  IN_SIZE*DATAWIDTH  input words; word k at bits [k*DATAWIDTH +: DATAWIDTH], word 0 is oldest
- din_valid  in  1  input beat valid
- din_ready  out  1  FIFO can take a full input beat
- dout  out  OUT_SIZE*DATAWIDTH  output words, same packing; word 0 is oldest
- dout_valid  out  1  output beat valid
- dout_ready  in  1  consumer accepts beat
- level  out  LVLW  words currently stored

Behaviour:
- Storage: ring of DEPTH word registers; wr_ptr and rd_ptr in 0..DEPTH-1.
  - Pointer advance is modulo DEPTH by compare-and-subtract; no power-of-two masking.
  - Storage is reset to 0.
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, count=0.
  - din_ready=1, dout_valid=0, dout=0, level=0.
- din_ready = (DEPTH - count >= IN_SIZE). Combinational from the registered count only.
- dout_valid = (count >= OUT_SIZE). Combinational from the registered count.
- dout is read combinationally at rd_ptr .. rd_ptr+OUT_SIZE-1 (mod DEPTH).
- Write: on din_valid & din_ready, store words 0..IN_SIZE-1 at wr_ptr.. (mod DEPTH); wr_ptr += IN_SIZE.
- Read: on dout_valid & dout_ready, rd_ptr += OUT_SIZE.
- count next state = count + (wr ? IN_SIZE : 0) - (rd ? OUT_SIZE : 0). level = count.
- Latency: words written at edge N appear in dout/dout_valid after edge N. There is no same-cycle bypass.
- Simultaneous read and write: both complete in the same cycle.
  - Space freed by the read is not visible to din_ready until the next cycle.
  - Data being written is not readable in the same cycle.
- Full: din_ready=0 and din is ignored, even if din_valid=1. Data is never lost or overwritten.
- Empty or partial (count < OUT_SIZE): dout_valid=0 and dout_ready is ignored.
- Wrap-around: a beat straddling index DEPTH-1 to 0 is split correctly. Required for DEPTH not a multiple of IN_SIZE or OUT_SIZE.
- dout is stable while dout_valid=1 and dout_ready=0 (AXI-stream rule). Upstream must hold din stable under din_valid & !din_ready.
- Reset asserted mid-operation: all contents discarded immediately and outputs return to reset values asynchronously.

Optional Feature:
- Macro: GEARBOX_FIFO_FLUSH_EN.
- With macro:
  - Extra ports: flush (in, 1; single-cycle pulse) and dout_keep (out, OUT_SIZE; bit k set when word k is real).
  - FSM with states NORMAL and DRAIN.
  - In NORMAL, a flush pulse moves the FSM to DRAIN at the next edge. If count=0, it stays in NORMAL.
  - In DRAIN:
    - din_ready=0 and dout_valid = (count > 0).
    - A beat with count < OUT_SIZE carries count real words; remaining words are 0 with keep low.
    - Handshake removes min(count, OUT_SIZE) words.
  - DRAIN returns to NORMAL at the edge where count becomes 0.
  - In NORMAL, dout_keep is all ones whenever dout_valid=1. Flush pulses arriving during DRAIN are ignored.
- Without macro: no flush or dout_keep ports. Behaviour is exactly as above, and a residual of fewer than OUT_SIZE words waits indefinitely.

Decomposition:
- Package gearbox_fifo_pkg holds:
  - function ptr_add(ptr, inc, depth) for modulo advance
  - function clog2-based width helpers
  - FSM state enum {NORMAL, DRAIN}
- One natural sub-module: gearbox_ring, the register array with multi-word write port and multi-word read port, taking wr_ptr and rd_ptr. Control, count and FSM stay in the top.

Test Plan:
- Defaults (14:1, DEPTH 28). Write one beat of words 0x00..0x0D with dout_ready=1 → 14 consecutive dout beats 0x00..0x0D, first beat the cycle after acceptance. level goes 14→0.
- Defaults, dout_ready=0. Write two beats → level=28, din_ready=0. A third din_valid beat is not accepted. Release dout_ready → 28 words in order, no loss.
- IN_SIZE=4, OUT_SIZE=3, DEPTH=10. Stream 30 incrementing words with random valid/ready → output 0..29 in order. Covers wrap-around at non-multiple depth.
- Simultaneous handshake at count=13 (defaults): write and read in one cycle → count=26 next cycle. din_ready that cycle reflects 13 (=0, since 15 free < IN_SIZE is false... free=15 ≥14 → 1). Verify arithmetic at every count.
- rst_n pulled low while level=20 and dout_valid=1 → dout_valid=0, level=0, din_ready=1 immediately, without a clock edge.
- GEARBOX_FIFO_FLUSH_EN, IN_SIZE=4, OUT_SIZE=3. Write 4 words A,B,C,D, then pulse flush → beat {A,B,C} keep=111, then beat {D,0,0} keep=001, then return to NORMAL. din_ready=0 throughout DRAIN.
